// File: rtl/basys3_io_ports.sv
// ============================================================================
// Module   : basys3_io_ports
// Function : AVR I/O-space peripheral for switches, buttons, LEDs, a 4-digit
//            seven-segment display and a scanned 4x4 keypad.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module basys3_io_ports #(
    parameter int REFRESH_BITS = 18,
    parameter int SCAN_BITS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  io_a,
    output logic [7:0]  io_di,
    input  logic [7:0]  io_do,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [15:0] led,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    input  logic [3:0]  kypd_row,
    output logic [3:0]  kypd_col
);

    localparam logic [5:0] c_addr_sw_l    = 6'h00;
    localparam logic [5:0] c_addr_sw_h    = 6'h01;
    localparam logic [5:0] c_addr_btn     = 6'h02;
    localparam logic [5:0] c_addr_led_l   = 6'h03;
    localparam logic [5:0] c_addr_led_h   = 6'h04;
    localparam logic [5:0] c_addr_dig0    = 6'h05;
    localparam logic [5:0] c_addr_dig1    = 6'h06;
    localparam logic [5:0] c_addr_dig2    = 6'h07;
    localparam logic [5:0] c_addr_dig3    = 6'h08;
    localparam logic [5:0] c_addr_disp_en = 6'h09;
    localparam logic [5:0] c_addr_key     = 6'h0A;

    localparam logic [REFRESH_BITS-1:0] c_refresh_one = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    localparam logic [SCAN_BITS+1:0]    c_scan_one    = {{(SCAN_BITS+1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [SCAN_BITS+1:0]    r_scan;
    logic [7:0]              r_led_l;
    logic [7:0]              r_led_h;
    logic [7:0]              r_dig [4];
    logic [3:0]              r_disp_en;
    logic [7:0]              r_key;
    logic                    r_held;
    logic [1:0]              r_empty_cnt;
    logic [3:0]              r_row_s1;
    logic [3:0]              r_row_s2;

    logic [1:0] w_digit;
    logic [7:0] w_cur;
    logic [1:0] w_col;
    logic       w_sample;
    logic       w_hit;
    logic [1:0] w_row;
    logic [3:0] w_code;
    logic       w_press;
    logic       w_key_rd;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Index is {row, col}, matching the keypad legend
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'b00_00: key_code = 4'h1;  4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;  4'b00_11: key_code = 4'hA;
            4'b01_00: key_code = 4'h4;  4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;  4'b01_11: key_code = 4'hB;
            4'b10_00: key_code = 4'h7;  4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;  4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'h0;  4'b11_01: key_code = 4'hF;
            4'b11_10: key_code = 4'hE;  default:  key_code = 4'hD;
        endcase
    endfunction

    assign w_digit  = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_cur    = r_dig[w_digit];
    assign an       = ~((4'b0001 << w_digit) & r_disp_en);
    assign seg      = ~hex7(w_cur[3:0]);
    assign dp       = ~w_cur[7];
    assign led      = {r_led_h, r_led_l};

    assign w_col    = r_scan[SCAN_BITS+1 -: 2];
    assign kypd_col = ~(4'b0001 << w_col);
    assign w_sample = &r_scan[SCAN_BITS-1:0];
    assign w_hit    = ~&r_row_s2;
    assign w_code   = key_code(w_row, w_col);
    assign w_press  = w_sample & w_hit & ~r_held;
    assign w_key_rd = io_re & (io_a == c_addr_key);

    // Descending loop so the lowest active row index is the last one assigned
    always_comb begin
        w_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_s2[i]) begin
                w_row = 2'(i);
            end
        end
    end

    always_comb begin
        io_di = 8'h00;
        case (io_a)
            c_addr_sw_l:    io_di = sw[7:0];
            c_addr_sw_h:    io_di = sw[15:8];
            c_addr_btn:     io_di = {3'b000, btn};
            c_addr_led_l:   io_di = r_led_l;
            c_addr_led_h:   io_di = r_led_h;
            c_addr_dig0:    io_di = r_dig[0];
            c_addr_dig1:    io_di = r_dig[1];
            c_addr_dig2:    io_di = r_dig[2];
            c_addr_dig3:    io_di = r_dig[3];
            c_addr_disp_en: io_di = {4'b0000, r_disp_en};
            c_addr_key:     io_di = r_key;
            default:        io_di = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led_l   <= 8'h00;
            r_led_h   <= 8'h00;
            r_disp_en <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= 8'h00;
            end
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + c_refresh_one;
            if (io_we) begin
                case (io_a)
                    c_addr_led_l:   r_led_l   <= io_do;
                    c_addr_led_h:   r_led_h   <= io_do;
                    c_addr_dig0:    r_dig[0]  <= io_do;
                    c_addr_dig1:    r_dig[1]  <= io_do;
                    c_addr_dig2:    r_dig[2]  <= io_do;
                    c_addr_dig3:    r_dig[3]  <= io_do;
                    c_addr_disp_en: r_disp_en <= io_do[3:0];
                    default: ;
                endcase
            end
        end
    end

    // held only drops after four consecutive empty column samples (one full scan)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_s1    <= 4'hF;
            r_row_s2    <= 4'hF;
            r_scan      <= '0;
            r_key       <= 8'h00;
            r_held      <= 1'b0;
            r_empty_cnt <= 2'd0;
        end else begin
            r_row_s1 <= kypd_row;
            r_row_s2 <= r_row_s1;
            r_scan   <= r_scan + c_scan_one;
            if (w_press) begin
                r_key <= {1'b1, 3'b000, w_code};
            end else if (w_key_rd) begin
                r_key <= 8'h00;
            end
            if (w_sample) begin
                if (w_hit) begin
                    r_held      <= 1'b1;
                    r_empty_cnt <= 2'd0;
                end else if (r_empty_cnt == 2'd3) begin
                    r_held <= 1'b0;
                end else begin
                    r_empty_cnt <= r_empty_cnt + 2'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_basys3_io_ports.sv
// Directed bench for basys3_io_ports: register-map vector table plus
// display-window, keypad and asynchronous-reset sequences.
`default_nettype none

module tb_basys3_io_ports;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  io_a = 6'h00;
    logic [7:0]  io_di;
    logic [7:0]  io_do = 8'h00;
    logic        io_re = 1'b0;
    logic        io_we = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [4:0]  btn = 5'b00000;
    logic [15:0] led;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [3:0]  kypd_row;
    logic [3:0]  kypd_col;

    logic        press_active = 1'b0;
    logic [1:0]  press_row = 2'd0;
    logic [1:0]  press_col = 2'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its row low while its column is driven
    assign kypd_row = (press_active && !kypd_col[press_col]) ? ~(4'b0001 << press_row) : 4'hF;

    basys3_io_ports #(.REFRESH_BITS(6), .SCAN_BITS(3)) dut (
        .clk(clk), .rst(rst), .io_a(io_a), .io_di(io_di), .io_do(io_do),
        .io_re(io_re), .io_we(io_we), .sw(sw), .btn(btn), .led(led),
        .seg(seg), .dp(dp), .an(an), .kypd_row(kypd_row), .kypd_col(kypd_col)
    );

    typedef struct {
        logic [5:0]  a;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  exp_di;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_key(input string name, input logic [7:0] exp);
        io_a = 6'h0A;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (io_di[7]) break;
        end
        check(name, {8'h00, io_di}, {8'h00, exp});
    endtask

    task automatic clear_key(input string name);
        io_a  = 6'h0A;
        io_re = 1'b1;
        @(posedge clk);
        #1;
        io_re = 1'b0;
        check(name, {8'h00, io_di}, 16'h0000);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        press_row    = r;
        press_col    = c;
        press_active = 1'b1;
    endtask

    task automatic release_key();
        press_active = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    initial begin
        int  win;
        int  bad;
        int  segbad;
        logic seen;

        vecs[0]  = '{6'h00, 1'b0, 8'h00, 8'h5A, 16'h0000};
        vecs[1]  = '{6'h01, 1'b0, 8'h00, 8'hA5, 16'h0000};
        vecs[2]  = '{6'h02, 1'b0, 8'h00, 8'h13, 16'h0000};
        vecs[3]  = '{6'h03, 1'b1, 8'h3C, 8'h3C, 16'h003C};
        vecs[4]  = '{6'h04, 1'b1, 8'hC3, 8'hC3, 16'hC33C};
        vecs[5]  = '{6'h3F, 1'b0, 8'h00, 8'h00, 16'hC33C};
        vecs[6]  = '{6'h3F, 1'b1, 8'hFF, 8'h00, 16'hC33C};
        vecs[7]  = '{6'h02, 1'b1, 8'hFF, 8'h13, 16'hC33C};
        vecs[8]  = '{6'h05, 1'b1, 8'h70, 8'h70, 16'hC33C};
        vecs[9]  = '{6'h07, 1'b1, 8'h8B, 8'h8B, 16'hC33C};
        vecs[10] = '{6'h09, 1'b1, 8'h04, 8'h04, 16'hC33C};
        vecs[11] = '{6'h0A, 1'b1, 8'hFF, 8'h00, 16'hC33C};
        vecs[12] = '{6'h03, 1'b0, 8'h00, 8'h3C, 16'hC33C};
        vecs[13] = '{6'h08, 1'b0, 8'h00, 8'h00, 16'hC33C};

        // Reset values while rst is held low
        repeat (3) @(negedge clk);
        io_a = 6'h0A;
        #1;
        check("rst_led", led, 16'h0000);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_col", {12'h0, kypd_col}, 16'h000E);
        check("rst_key", {8'h00, io_di}, 16'h0000);
        check("rst_seg", {9'h0, seg}, 16'h0040);
        check("rst_dp", {15'h0, dp}, 16'h0001);

        // Column dwell is 8 clocks: col 0 for counts 0..7, col 1 from count 8
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("scan_col0_end", {12'h0, kypd_col}, 16'h000E);
        @(posedge clk);
        #1;
        check("scan_col1", {12'h0, kypd_col}, 16'h000D);

        sw  = 16'hA55A;
        btn = 5'b10011;
        foreach (vecs[i]) begin
            io_a  = vecs[i].a;
            io_we = vecs[i].we;
            io_do = vecs[i].wd;
            @(posedge clk);
            #1;
            io_we = 1'b0;
            check($sformatf("vec%0d_di", i), {8'h00, io_di}, {8'h00, vecs[i].exp_di});
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
        end

        // Display: DIG2 = 0x8B enabled alone; 16-clock window per digit
        win = 0; bad = 0; segbad = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (an == 4'b1011) begin
                win++;
                if (seg !== 7'b0000011 || dp !== 1'b0) segbad++;
            end else if (an !== 4'b1111) begin
                bad++;
            end
        end
        check("disp_window_len", 16'(win), 16'd16);
        check("disp_other_an", 16'(bad), 16'd0);
        check("disp_seg_dp", 16'(segbad), 16'd0);

        // Keypad: r1 x c2 -> '6'
        press(2'd1, 2'd2);
        wait_key("key_r1c2", 8'h86);
        clear_key("key_clear1");
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (io_di[7]) seen = 1'b1;
        end
        check("key_no_repeat", {15'h0, seen}, 16'h0000);
        release_key();

        press(2'd3, 2'd0);
        wait_key("key_r3c0", 8'h80);
        clear_key("key_clear2");
        release_key();

        // Race: read strobe held high across the press event
        io_a  = 6'h0A;
        io_re = 1'b1;
        press(2'd0, 2'd3);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (io_di[7]) break;
        end
        check("race_press_wins", {8'h00, io_di}, 16'h008A);
        @(negedge clk);
        check("race_cleared", {8'h00, io_di}, 16'h0000);
        io_re = 1'b0;
        release_key();

        // Asynchronous reset mid-operation with a key pending
        press(2'd2, 2'd1);
        wait_key("key_r2c1", 8'h88);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_led", led, 16'h0000);
        check("arst_an", {12'h0, an}, 16'h000F);
        check("arst_col", {12'h0, kypd_col}, 16'h000E);
        check("arst_key", {8'h00, io_di}, 16'h0000);
        check("arst_dp", {15'h0, dp}, 16'h0001);
        press_active = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/basys3_io_ports.md
# basys3_io_ports

Memory-mapped I/O peripheral for the Basys3 soft-AVR system. It sits on the AVR core's 6-bit I/O bus (IN/OUT space) and exposes:
- the 16 slide switches and 5 push buttons (read),
- the 16 LEDs (read/write),
- a multiplexed 4-digit hex seven-segment display,
- a scanned 4×4 PmodKYPD keypad on port JB.

All logic runs on the single 100 MHz board clock.

## Interface
Parameters:
- REFRESH_BITS, 18, display refresh counter width; the top 2 bits select the active digit.
- SCAN_BITS, 16, keypad column dwell is 2^SCAN_BITS clocks.

Ports:
- clk  input  1  100 MHz clock; one clock domain, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- io_a  input  6  I/O register address.
- io_di  output  8  read data to core, combinational mux of io_a.
- io_do  input  8  write data from core.
- io_re  input  1  read strobe.
- io_we  input  1  write strobe.
- sw  input  16  slide switches.
- btn  input  5  buttons, bit order {D,R,L,U,C}.
- led  output  16  LED drive, 1 = on.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] = rightmost digit.
- kypd_row  input  4  keypad rows (JB[7:4]), active-low with pull-ups.
- kypd_col  output  4  keypad columns (JB[3:0]); one driven low at a time.

## Operation
Register map (io_a). Unlisted addresses read 0x00 and ignore writes.
- 0x00 SW_L (R): sw[7:0].
- 0x01 SW_H (R): sw[15:8].
- 0x02 BTN (R): {3'b0, btn}.
- 0x03 LED_L (R/W): led[7:0].
- 0x04 LED_H (R/W): led[15:8].
- 0x05–0x08 DIG0–DIG3 (R/W): bits [3:0] hex value, bit 7 dp on. Bits [6:4] are stored but have no effect.
- 0x09 DISP_EN (R/W): bit i enables digit i. A disabled digit keeps its an bit high.
- 0x0A KEY (R): bit 7 = valid, bits [3:0] = key code.
  - A read with io_re high clears valid at the next clock edge.
  - The cleared value is 0x00.
  - A new key press in the same cycle as the clear wins: valid = 1 with the new code.

Write behaviour:
- Writes occur on a clock edge with io_we high; data is taken from io_do.
- Strobes may stay high for several clocks; repeated writes and reads are idempotent.

Display:
- The free-running counter refresh[REFRESH_BITS-1:0] selects digit d = refresh[top:top-1].
- The selected digit drives an = ~(1<<d) & ~DISP_EN-gated, i.e. an[d] is low only when DISP_EN[d] = 1.
- seg = active-low hex decode of DIGd[3:0]; dp = ~DIGd[7].
- Hex patterns for a..g (1 = lit):
  - 0: 0x3F, 1: 0x06, 2: 0x5B, 3: 0x4F
  - 4: 0x66, 5: 0x6D, 6: 0x7D, 7: 0x07
  - 8: 0x7F, 9: 0x6F, A: 0x77, b: 0x7C
  - C: 0x39, d: 0x5E, E: 0x79, F: 0x71

Keypad:
- kypd_row passes through a 2-flop synchronizer.
- Column c (0..3) is driven low for 2^SCAN_BITS clocks, then the scan moves to c+1, wrapping 3→0.
- Rows are sampled on the last clock of each dwell.
- Key layout, rows r0..r3 × cols c0..c3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Multiple rows low in one column: the lowest row index wins.
- Press event: a key is detected and the held flag is 0. On a press event, KEY = {1'b1, 3'b0, code} and held is set to 1.
- held clears only after a complete 4-column scan finds no row low. One press therefore produces exactly one event (auto-repeat is not supported).

## Timing
- Reset values:
  - led = 0; DIG0–3 = 0x00; DISP_EN = 0, so an = 4'b1111.
  - seg shows the hex decode of 0; dp = 1.
  - KEY = 0x00; held = 0.
  - refresh and scan counters = 0; kypd_col = 4'b1110.
- Writes are visible on outputs and readback one clock after the write edge.
- io_di has zero latency from io_a, with no dependence on io_re.
- Key valid asserts on the clock after the sampling edge of the detecting column.
- Reset asserted mid-scan or mid-refresh returns all state to reset values immediately (asynchronous).

## Test plan
Benches use REFRESH_BITS = 6 and SCAN_BITS = 3.
- Reset: drive rst low mid-operation -> led = 0x0000, an = 4'b1111, kypd_col = 4'b1110, KEY reads 0x00.
- Switches and buttons: sw = 0xA55A, btn = 5'b10011 -> 0x00 reads 0x5A, 0x01 reads 0xA5, 0x02 reads 0x13.
- LEDs: write 0x03 = 0x3C, then 0x04 = 0xC3 -> led = 0xC33C one clock later; readback matches; address 0x3F reads 0x00.
- Display: write DIG2 = 0x8B, DISP_EN = 0x04 -> during the digit-2 window an = 4'b1011, seg = ~0x7C = 7'b0000011, dp = 0; all other windows an = 4'b1111.
- Keypad: hold r1 low while col c2 is driven -> KEY = 0x86; second read after the clear = 0x00; continuous hold produces no new event; release for a full scan, then press r3 with c0 -> KEY = 0x80.
- Clear/press race: a KEY read coinciding with a new press event -> valid remains 1 with the new code.
